// File: rtl/cmp_operand_debounce.sv
// rtl/cmp_operand_debounce.sv - synchronize and debounce four switch pins into zero-extended compare operands
// Optional feature macro: CMP_DEBOUNCE_EN (defined: per-pin debounce counters; undefined: sync only).
module cmp_operand_debounce #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int WIDTH           = 8
) (
  input  logic             CLKIN,
  input  logic             RESETN,
  input  logic             A0,
  input  logic             A1,
  input  logic             B0,
  input  logic             B1,
  output logic [WIDTH-1:0] I0,
  output logic [WIDTH-1:0] I1,
  output logic             VALID
);

  logic [3:0] pins;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] stable_q;
  logic [3:0] stable_d;
  logic       valid_q;
  logic       valid_d;

  assign pins = {B1, B0, A1, A0};

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= pins;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      valid_q  <= valid_d;
    end
  end

`ifdef CMP_DEBOUNCE_EN
  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  // Any cycle where the pin agrees with its committed value discards the run so far.
  always_comb begin
    stable_d = stable_q;
    for (int p = 0; p < 4; p++) begin
      cnt_d[p] = '0;
      if (sync2_q[p] != stable_q[p]) begin
        if (cnt_q[p] == CNT_MAX) begin
          stable_d[p] = sync2_q[p];
        end else begin
          cnt_d[p] = cnt_q[p] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      for (int p = 0; p < 4; p++) begin
        cnt_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        cnt_q[p] <= cnt_d[p];
      end
    end
  end
`else
  assign stable_d = sync2_q;
`endif

  // VALID registers alongside stable_q so it is high in the first cycle I0/I1 show the change.
  assign valid_d = |(stable_d ^ stable_q);
  assign VALID   = valid_q;

  always_comb begin
    I0      = '0;
    I1      = '0;
    I0[1:0] = stable_q[1:0];
    I1[1:0] = stable_q[3:2];
  end

endmodule

// File: tb/tb_cmp_operand_debounce.sv
// tb/tb_cmp_operand_debounce.sv - randomized model-checked bench for cmp_operand_debounce
module tb_cmp_operand_debounce;

  localparam int DC = 4;
  localparam int W  = 8;
`ifdef CMP_DEBOUNCE_EN
  localparam int EFF_D = DC;
`else
  localparam int EFF_D = 1;
`endif
  localparam int LAT = EFF_D + 2;

  logic         CLKIN  = 1'b0;
  logic         RESETN = 1'b0;
  logic         A0 = 1'b0;
  logic         A1 = 1'b0;
  logic         B0 = 1'b0;
  logic         B1 = 1'b0;
  logic [W-1:0] I0;
  logic [W-1:0] I1;
  logic         VALID;

  int n_checks = 0;
  int n_pass   = 0;

  cmp_operand_debounce #(.DEBOUNCE_CYCLES(DC), .WIDTH(W)) dut (
    .CLKIN (CLKIN),
    .RESETN(RESETN),
    .A0    (A0),
    .A1    (A1),
    .B0    (B0),
    .B1    (B1),
    .I0    (I0),
    .I1    (I1),
    .VALID (VALID)
  );

  always #5 CLKIN = ~CLKIN;

  // Model: a pin commits once its last EFF_D samples (seen two edges late) all differ from the committed value.
  bit hist [4][LAT];
  bit m_stable [4];
  bit m_valid;

  function automatic logic [2*W:0] pack(input logic [W-1:0] i0, input logic [W-1:0] i1, input logic v);
    return {i0, i1, v};
  endfunction

  function automatic logic [2*W:0] model_out();
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    e0 = '0;
    e1 = '0;
    e0[1:0] = {m_stable[1], m_stable[0]};
    e1[1:0] = {m_stable[3], m_stable[2]};
    return {e0, e1, m_valid};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      m_stable[p] = 1'b0;
      for (int k = 0; k < LAT; k++) hist[p][k] = 1'b0;
    end
    m_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got I0/I1/VALID=%h expected %h at %0t", name, act, exp, $time);
  endtask

  initial begin : model_proc
    logic [3:0] pv;
    bit commit;
    bit all_diff;
    model_reset();
    forever begin
      @(posedge CLKIN);
      pv = {B1, B0, A1, A0};
      if (!RESETN) begin
        model_reset();
      end else begin
        commit = 1'b0;
        for (int p = 0; p < 4; p++) begin
          all_diff = 1'b1;
          for (int k = 1; k <= EFF_D; k++) if (hist[p][k] == m_stable[p]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[p] = ~m_stable[p];
            commit = 1'b1;
          end
          for (int k = LAT - 1; k > 0; k--) hist[p][k] = hist[p][k-1];
          hist[p][0] = pv[p];
        end
        m_valid = commit;
      end
      @(negedge CLKIN);
      if (!RESETN) model_reset();
      check("model", {I0, I1, VALID}, model_out());
    end
  end

  task automatic tick();
    @(posedge CLKIN);
    #1;
  endtask

  task automatic set_pins(input logic [3:0] v);
    {B1, B0, A1, A0} = v;
  endtask

  initial begin
    int rst_left;
    // Reset with all pins high, then the release commit.
    set_pins(4'hF);
    RESETN = 1'b0;
    repeat (3) tick();
    @(negedge CLKIN);
    check("reset_hold", {I0, I1, VALID}, pack(8'h00, 8'h00, 1'b0));
    tick();
    RESETN = 1'b1;
    for (int i = 0; i <= LAT + 1; i++) begin
      @(negedge CLKIN);
      if (i < LAT) check("release_wait", {I0, I1, VALID}, pack(8'h00, 8'h00, 1'b0));
      else if (i == LAT) check("release_commit", {I0, I1, VALID}, pack(8'h03, 8'h03, 1'b1));
      else check("release_after", {I0, I1, VALID}, pack(8'h03, 8'h03, 1'b0));
    end

    // Back to all-zero, then a clean A0 rise.
    tick();
    set_pins(4'h0);
    RESETN = 1'b0;
    repeat (2) tick();
    RESETN = 1'b1;
    repeat (LAT + 2) tick();
    A0 = 1'b1;
    for (int i = 0; i <= LAT + 1; i++) begin
      @(negedge CLKIN);
      if (i < LAT) check("clean_wait", {I0, I1, VALID}, pack(8'h00, 8'h00, 1'b0));
      else if (i == LAT) check("clean_commit", {I0, I1, VALID}, pack(8'h01, 8'h00, 1'b1));
      else check("clean_after", {I0, I1, VALID}, pack(8'h01, 8'h00, 1'b0));
    end
    tick();

`ifdef CMP_DEBOUNCE_EN
    // B1 bounce: high 3, low 1, then high steadily.
    B1 = 1'b1;
    repeat (3) tick();
    B1 = 1'b0;
    tick();
    B1 = 1'b1;
    for (int i = 0; i <= LAT + 1; i++) begin
      @(negedge CLKIN);
      if (i < LAT) check("bounce_wait", {I0, I1, VALID}, pack(8'h01, 8'h00, 1'b0));
      else if (i == LAT) check("bounce_commit", {I0, I1, VALID}, pack(8'h01, 8'h02, 1'b1));
      else check("bounce_after", {I0, I1, VALID}, pack(8'h01, 8'h02, 1'b0));
    end
    tick();
    // Reset two cycles into an A1 count: nothing commits, then it commits after release.
    A1 = 1'b1;
    repeat (4) tick();
    RESETN = 1'b0;
    @(negedge CLKIN);
    check("midreset_clear", {I0, I1, VALID}, pack(8'h00, 8'h00, 1'b0));
    tick();
    RESETN = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      @(negedge CLKIN);
      if (i < LAT) check("midreset_wait", {I0, I1, VALID}, pack(8'h00, 8'h00, 1'b0));
      else check("midreset_commit", {I0, I1, VALID}, pack(8'h03, 8'h02, 1'b1));
    end
    tick();
`else
    // One-cycle A0 pulse passes straight through, with a pulse on each edge.
    A0 = 1'b0;
    repeat (LAT + 2) tick();
    A0 = 1'b1;
    @(negedge CLKIN);
    check("pulse_0", {I0, I1, VALID}, pack(8'h00, 8'h00, 1'b0));
    tick();
    A0 = 1'b0;
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge CLKIN);
      if (i == LAT) check("pulse_rise", {I0, I1, VALID}, pack(8'h01, 8'h00, 1'b1));
      else if (i == LAT + 1) check("pulse_fall", {I0, I1, VALID}, pack(8'h00, 8'h00, 1'b1));
      else check("pulse_idle", {I0, I1, VALID}, pack(8'h00, 8'h00, 1'b0));
    end
    tick();
`endif

    // Random pin activity with occasional resets; the model process checks every cycle.
    rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) A0 = ~A0;
      if ($urandom_range(0, 7) == 0) A1 = ~A1;
      if ($urandom_range(0, 9) == 0) B0 = ~B0;
      if ($urandom_range(0, 5) == 0) B1 = ~B1;
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) RESETN = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        RESETN   = 1'b0;
        rst_left = $urandom_range(1, 3);
      end
      tick();
    end
    RESETN = 1'b1;
    repeat (LAT + 3) tick();
    @(negedge CLKIN);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
